// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: issues one imem fetch at a time from the PC register,
// holds the result for decode and pulses PCWr on accept or redirect.
module ifetch_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] PC,
    output logic              PCWr,
    input  logic              redirect,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              fetch_fault,
    output logic [31:0]       fetch_count
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;

    state_t            state;
    logic              drop_q;
    logic [DATA_W-1:0] inst_q;
    logic [ADDR_W-1:0] pc_q;
    logic              aligned;

    assign aligned     = (PC[1:0] == 2'b00);
    assign imem_req    = (state == REQ) && aligned;
    assign imem_addr   = imem_req ? {PC[ADDR_W-1:2], 2'b00} : '0;
    assign inst_valid  = (state == HOLD);
    assign inst        = inst_q;
    assign inst_pc     = pc_q;
    assign fetch_fault = (state == FAULT);

    // A redirect and a HOLD accept in the same cycle collapse into one pulse.
    assign PCWr = !rst && (redirect || ((state == HOLD) && inst_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            drop_q      <= 1'b0;
            inst_q      <= '0;
            pc_q        <= '0;
            fetch_count <= '0;
        end else if (redirect) begin
            case (state)
                IDLE: state <= IDLE;
                REQ: begin
                    if (imem_req && imem_gnt) begin
                        drop_q <= 1'b1;
                        state  <= WAIT;
                    end else begin
                        state <= REQ;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        drop_q <= 1'b0;
                        state  <= REQ;
                    end else begin
                        drop_q <= 1'b1;
                    end
                end
                HOLD:    state <= REQ;
                FAULT:   state <= REQ;
                default: state <= IDLE;
            endcase
        end else begin
            case (state)
                IDLE: if (fetch_en) state <= REQ;
                REQ: begin
                    if (!aligned) begin
                        state <= FAULT;
                    end else begin
                        pc_q <= PC;
                        if (imem_gnt) state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_q <= 1'b0;
                            state  <= REQ;
                        end else begin
                            inst_q <= imem_rdata;
                            state  <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        fetch_count <= fetch_count + 32'd1;
                        state       <= fetch_en ? REQ : IDLE;
                    end
                end
                FAULT:   state <= FAULT;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a small PC-register model (PC+4 or redirect target).
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [31:0] pc;
    logic        PCWr;
    logic        redirect;
    logic [31:0] target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    ifetch_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_en   (fetch_en),
        .PC         (pc),
        .PCWr       (PCWr),
        .redirect   (redirect),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready),
        .fetch_fault(fetch_fault),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // PC register environment: loads NPC when PCWr pulses.
    always @(posedge clk) begin
        if (rst) pc <= 32'h0;
        else if (PCWr) pc <= redirect ? target : pc + 32'd4;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Move to the next negedge, apply inputs, settle for sampling.
    task automatic step(input logic fe, input logic gnt, input logic rv, input logic [31:0] rd,
                        input logic rdy, input logic rdir, input logic [31:0] tgt);
        @(negedge clk);
        fetch_en    = fe;
        imem_gnt    = gnt;
        imem_rvalid = rv;
        imem_rdata  = rd;
        inst_ready  = rdy;
        redirect    = rdir;
        target      = tgt;
        #1;
    endtask

    initial begin
        rst = 1'b1; fetch_en = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        inst_ready = 0; redirect = 0; target = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        chk("rst_pcwr", PCWr, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_fault", fetch_fault, 0);
        chk("rst_inst", inst, 0);
        chk("rst_instpc", inst_pc, 0);
        chk("rst_count", fetch_count, 0);
        chk("rst_addr", imem_addr, 0);

        // basic fetch at PC 0
        step(1, 0, 0, 0, 1, 0, 0);                      // IDLE
        step(1, 1, 0, 0, 1, 0, 0);                      // REQ
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 32'h0);
        step(1, 0, 1, 32'h00500093, 1, 0, 0);           // WAIT
        chk("t1_wait_req", imem_req, 0);
        step(1, 0, 0, 0, 1, 0, 0);                      // HOLD
        chk("t1_valid", inst_valid, 1);
        chk("t1_inst", inst, 32'h00500093);
        chk("t1_instpc", inst_pc, 32'h0);
        chk("t1_pcwr", PCWr, 1);
        step(1, 1, 0, 0, 0, 0, 0);                      // REQ at 4
        chk("t1_count", fetch_count, 1);
        chk("t1_addr4", imem_addr, 32'h4);
        chk("t1_pcwr_once", PCWr, 0);

        // decode stall for 5 cycles
        step(1, 0, 1, 32'h00A00113, 0, 0, 0);           // WAIT
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            chk("t2_valid", inst_valid, 1);
            chk("t2_inst", inst, 32'h00A00113);
            chk("t2_instpc", inst_pc, 32'h4);
            chk("t2_pcwr", PCWr, 0);
            chk("t2_req", imem_req, 0);
        end
        step(1, 0, 0, 0, 1, 0, 0);
        chk("t2_accept", PCWr, 1);
        step(1, 1, 0, 0, 0, 0, 0);                      // REQ at 8
        chk("t2_count", fetch_count, 2);
        chk("t2_addr8", imem_addr, 32'h8);

        // redirect while waiting; late data dropped
        step(1, 0, 0, 0, 0, 1, 32'h100);                // WAIT + redirect
        chk("t3_pcwr", PCWr, 1);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 32'hDEADBEEF, 0, 0, 0);           // stale rvalid
        chk("t3_novalid", inst_valid, 0);
        step(1, 1, 0, 0, 0, 0, 0);                      // REQ at 0x100
        chk("t3_novalid2", inst_valid, 0);
        chk("t3_addr", imem_addr, 32'h100);
        chk("t3_count", fetch_count, 2);

        // redirect and ready in the same HOLD cycle
        step(1, 0, 1, 32'h12345678, 0, 0, 0);           // WAIT
        step(1, 0, 0, 0, 1, 1, 32'h180);                // HOLD
        chk("t4_pcwr", PCWr, 1);
        step(1, 0, 0, 0, 0, 0, 0);                      // REQ at 0x180
        chk("t4_count", fetch_count, 2);
        chk("t4_novalid", inst_valid, 0);
        chk("t4_addr", imem_addr, 32'h180);

        // misaligned PC -> fault, redirect out
        step(1, 0, 0, 0, 0, 1, 32'h102);                // REQ redirect w/o gnt
        step(1, 1, 0, 0, 0, 0, 0);                      // REQ with PC 0x102
        chk("t5_noreq", imem_req, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("t5_fault", fetch_fault, 1);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("t5_fault_held", fetch_fault, 1);
        chk("t5_noreq2", imem_req, 0);
        step(1, 0, 0, 0, 0, 1, 32'h200);
        chk("t5_pcwr", PCWr, 1);
        step(1, 1, 0, 0, 0, 0, 0);                      // REQ at 0x200
        chk("t5_clear", fetch_fault, 0);
        chk("t5_addr", imem_addr, 32'h200);

        // fetch_count wrap
        step(1, 0, 1, 32'h00000013, 0, 0, 0);           // WAIT
        step(1, 0, 0, 0, 0, 0, 0);                      // HOLD
        force dut.fetch_count = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_count;
        #1;
        chk("t6_preload", fetch_count, 32'hFFFF_FFFF);
        step(1, 0, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);                      // REQ at 0x204
        chk("t6_wrap", fetch_count, 0);
        chk("t6_addr", imem_addr, 32'h204);

        // reset during WAIT, stale rvalid afterwards
        step(1, 0, 0, 0, 0, 0, 0);                      // WAIT
        rst = 1'b1;
        step(0, 0, 1, 32'hCAFEF00D, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("t7_req", imem_req, 0);
        chk("t7_valid", inst_valid, 0);
        chk("t7_inst", inst, 0);
        chk("t7_count", fetch_count, 0);
        chk("t7_addr", imem_addr, 0);
        chk("t7_instpc", inst_pc, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("t7_stale_valid", inst_valid, 0);
        chk("t7_stale_pcwr", PCWr, 0);
        chk("t7_stale_inst", inst, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
